// File: rtl/spi_reg_frame_engine.sv
// Quad-SPI register-bank frame engine: nibble-serial cmd/addr/data frames into a DEPTH-byte bank.
// Optional status/error-counter commands (0x05/0x06) are compiled in when SPI_STATUS_CMD_EN is defined.
module spi_reg_frame_engine #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DUMMY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_cs,
  input  logic [3:0]    spi_d_in,
  output logic [3:0]    spi_d_out,
  output logic [3:0]    spi_d_oe,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_byte
);

  localparam int unsigned CW = (DUMMY > 1) ? $clog2(DUMMY) : 1;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;
`ifdef SPI_STATUS_CMD_EN
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_CLEAR  = 8'h06;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_LO,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WR_HI,
    S_WR_LO,
    S_DUMMY,
    S_RD,
    S_IGNORE,
    S_WAIT_END
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    hold_q, hold_d;       // cmd hi / addr hi / write hi / pending read lo nibble
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_mode_q, wr_mode_d;
  logic          lo_next_q, lo_next_d;
  logic [3:0]    dout_q, dout_d;
  logic [3:0]    oe_q, oe_d;
  logic [7:0]    regs_q [DEPTH];
  logic          wr_en;
  logic [7:0]    frame_byte;
  logic [7:0]    rd_byte;
`ifdef SPI_STATUS_CMD_EN
  logic          stat_q, stat_d;
  logic [7:0]    err_q, err_d;
`endif

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_mode_d  = wr_mode_q;
    lo_next_d  = lo_next_q;
    dout_d     = dout_q;
    oe_d       = 4'h0;
    wr_en      = 1'b0;
    frame_byte = {hold_q, spi_d_in};
    rd_byte    = regs_q[addr_q];
`ifdef SPI_STATUS_CMD_EN
    stat_d     = stat_q;
    err_d      = err_q;
    if (stat_q) rd_byte = err_q;
`endif
    if (!spi_cs) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT_END: state_d = S_WAIT_END;
        S_IDLE: begin
          hold_d  = spi_d_in;
          state_d = S_CMD_LO;
        end
        S_CMD_LO: begin
`ifdef SPI_STATUS_CMD_EN
          stat_d = 1'b0;
`endif
          case (frame_byte)
            CMD_WRITE: begin
              wr_mode_d = 1'b1;
              state_d   = S_ADDR_HI;
            end
            CMD_READ: begin
              wr_mode_d = 1'b0;
              state_d   = S_ADDR_HI;
            end
`ifdef SPI_STATUS_CMD_EN
            CMD_STATUS: begin
              stat_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_DUMMY;
            end
            CMD_CLEAR: begin
              err_d   = 8'h00;
              state_d = S_IGNORE;
            end
`endif
            default: begin
`ifdef SPI_STATUS_CMD_EN
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
              state_d = S_IGNORE;
            end
          endcase
        end
        S_ADDR_HI: begin
          hold_d  = spi_d_in;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = AW'(frame_byte);
          cnt_d   = '0;
          state_d = wr_mode_q ? S_WR_HI : S_DUMMY;
        end
        S_WR_HI: begin
          hold_d  = spi_d_in;
          state_d = S_WR_LO;
        end
        S_WR_LO: begin
          wr_en   = 1'b1;
          addr_d  = addr_q + AW'(1);
          state_d = S_WR_HI;
        end
        S_DUMMY: begin
          if (cnt_q == CW'(DUMMY - 1)) begin
            oe_d      = 4'hF;
            dout_d    = rd_byte[7:4];
            hold_d    = rd_byte[3:0];
            lo_next_d = 1'b1;
            state_d   = S_RD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RD: begin
          oe_d = 4'hF;
          if (lo_next_q) begin
            dout_d    = hold_q;
            lo_next_d = 1'b0;
`ifdef SPI_STATUS_CMD_EN
            if (!stat_q) addr_d = addr_q + AW'(1);
`else
            addr_d = addr_q + AW'(1);
`endif
          end else begin
            dout_d    = rd_byte[7:4];
            hold_d    = rd_byte[3:0];
            lo_next_d = 1'b1;
          end
        end
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_WAIT_END;
      endcase
    end
  end

  // State and register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT_END;
      hold_q    <= 4'h0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_mode_q <= 1'b0;
      lo_next_q <= 1'b0;
      dout_q    <= 4'h0;
      oe_q      <= 4'h0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
`ifdef SPI_STATUS_CMD_EN
      stat_q    <= 1'b0;
      err_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_mode_q <= wr_mode_d;
      lo_next_q <= lo_next_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      if (wr_en) regs_q[addr_q] <= frame_byte;
`ifdef SPI_STATUS_CMD_EN
      stat_q    <= stat_d;
      err_q     <= err_d;
`endif
    end
  end

  assign spi_d_out = dout_q;
  assign spi_d_oe  = oe_q;
  assign dbg_byte  = regs_q[dbg_addr];

endmodule

// File: tb/tb_spi_reg_frame_engine.sv
// Self-checking bench for spi_reg_frame_engine: directed frames plus randomized frames against a frame-level model.
module tb_spi_reg_frame_engine;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DUMMY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_cs = 1'b0;
  logic [3:0]    spi_d_in = 4'h0;
  logic [3:0]    spi_d_out;
  logic [3:0]    spi_d_oe;
  logic [AW-1:0] dbg_addr = '0;
  logic [7:0]    dbg_byte;

  int checks = 0;
  int errors = 0;

  logic [7:0] mregs [DEPTH];
  int         merr;
  logic [3:0] frm[$];
  logic [3:0] exp_oe[$], exp_do[$], obs_oe[$], obs_do[$];
  logic [7:0] exp_dbg[$], obs_dbg[$];
  logic [3:0] end_oe;

  spi_reg_frame_engine #(.DEPTH(DEPTH), .AW(AW), .DUMMY(DUMMY)) dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_d_in(spi_d_in),
    .spi_d_out(spi_d_out), .spi_d_oe(spi_d_oe), .dbg_addr(dbg_addr), .dbg_byte(dbg_byte)
  );

  always #5 clk = ~clk;

  function automatic bit cmd_known(input logic [7:0] c);
`ifdef SPI_STATUS_CMD_EN
    return (c == 8'h02) || (c == 8'h0B) || (c == 8'h05) || (c == 8'h06);
`else
    return (c == 8'h02) || (c == 8'h0B);
`endif
  endfunction

  task automatic push_byte(input logic [7:0] b);
    frm.push_back(b[7:4]);
    frm.push_back(b[3:0]);
  endtask

  // Frame-level reference: expected oe/dout/dbg after every selected edge of frm
  task automatic model_frame(input logic [AW-1:0] dsel);
    int n, addr, off;
    logic [7:0] cmd, b;
    logic [3:0] oe, dout;
    n = frm.size();
    exp_oe.delete(); exp_do.delete(); exp_dbg.delete();
    cmd = 8'h00;
    addr = 0;
    if (n >= 2) cmd = {frm[0], frm[1]};
    if (n >= 4) addr = int'({frm[2], frm[3]}) % DEPTH;
    for (int k = 0; k < n; k++) begin
      oe = 4'h0;
      dout = 4'h0;
      if (k == 1 && !cmd_known(cmd)) merr = (merr >= 255) ? 255 : merr + 1;
`ifdef SPI_STATUS_CMD_EN
      if (k == 1 && cmd == 8'h06) merr = 0;
      if (cmd == 8'h05 && k >= 1 + DUMMY) begin
        off = k - 1 - DUMMY;
        b = 8'(merr);
        oe = 4'hF;
        dout = (off % 2 == 0) ? b[7:4] : b[3:0];
      end
`endif
      if (cmd == 8'h02 && k >= 5 && (k % 2) == 1)
        mregs[AW'((addr + (k - 5) / 2) % DEPTH)] = {frm[k-1], frm[k]};
      if (cmd == 8'h0B && k >= 3 + DUMMY) begin
        off = k - 3 - DUMMY;
        b = mregs[AW'((addr + off / 2) % DEPTH)];
        oe = 4'hF;
        dout = (off % 2 == 0) ? b[7:4] : b[3:0];
      end
      exp_oe.push_back(oe);
      exp_do.push_back(dout);
      exp_dbg.push_back(mregs[dsel]);
    end
  endtask

  // Drives frm with spi_cs high, then exactly one spi_cs-low edge
  task automatic drive_frame(input logic [AW-1:0] dsel);
    obs_oe.delete(); obs_do.delete(); obs_dbg.delete();
    dbg_addr = dsel;
    foreach (frm[i]) begin
      @(negedge clk);
      spi_cs = 1'b1;
      spi_d_in = frm[i];
      @(posedge clk);
      #1;
      obs_oe.push_back(spi_d_oe);
      obs_do.push_back(spi_d_out);
      obs_dbg.push_back(dbg_byte);
    end
    @(negedge clk);
    spi_cs = 1'b0;
    spi_d_in = 4'($urandom);
    @(posedge clk);
    #1;
    end_oe = spi_d_oe;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    spi_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (spi_d_oe !== 4'h0 || spi_d_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got oe=%h dout=%h, want 0/0", spi_d_oe, spi_d_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_byte !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want 00", i, dbg_byte);
      end
    end
    foreach (mregs[i]) mregs[i] = 8'h00;
    merr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write;
    frm.delete();
    push_byte(8'h02); push_byte(8'h03); push_byte(8'hA5); push_byte(8'h5A);
    model_frame(3);
    drive_frame(3);
    for (int k = 0; k < exp_oe.size(); k++) begin
      checks++;
      if (obs_oe[k] !== exp_oe[k] || obs_dbg[k] !== exp_dbg[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
        errors++;
        $display("FAIL write edge %0d: got oe=%h dout=%h dbg=%h, want oe=%h dout=%h dbg=%h",
                 k, obs_oe[k], obs_do[k], obs_dbg[k], exp_oe[k], exp_do[k], exp_dbg[k]);
      end
    end
    checks++;
    if (obs_dbg[4] !== 8'h00 || obs_dbg[5] !== 8'hA5) begin
      errors++;
      $display("FAIL write_commit_edge: got dbg %h/%h, want 00/A5", obs_dbg[4], obs_dbg[5]);
    end
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_byte !== 8'hA5) begin errors++; $display("FAIL write_reg3: got %h want A5", dbg_byte); end
    dbg_addr = 3'd4; #1;
    checks++;
    if (dbg_byte !== 8'h5A) begin errors++; $display("FAIL write_reg4: got %h want 5A", dbg_byte); end
  endtask

  task automatic test_read;
    logic [3:0] want[4] = '{4'hA, 4'h5, 4'h5, 4'hA};
    frm.delete();
    push_byte(8'h0B); push_byte(8'h03);
    repeat (5) frm.push_back(4'($urandom));
    model_frame(0);
    drive_frame(0);
    for (int k = 0; k < exp_oe.size(); k++) begin
      checks++;
      if (obs_oe[k] !== exp_oe[k] || obs_dbg[k] !== exp_dbg[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
        errors++;
        $display("FAIL read edge %0d: got oe=%h dout=%h dbg=%h, want oe=%h dout=%h dbg=%h",
                 k, obs_oe[k], obs_do[k], obs_dbg[k], exp_oe[k], exp_do[k], exp_dbg[k]);
      end
    end
    checks++;
    if (obs_oe[4] !== 4'h0 || obs_oe[5] !== 4'hF) begin
      errors++;
      $display("FAIL read_oe_rise: got oe4=%h oe5=%h, want 0/F", obs_oe[4], obs_oe[5]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_do[5+i] !== want[i]) begin
        errors++;
        $display("FAIL read_nibble%0d: got %h want %h", i, obs_do[5+i], want[i]);
      end
    end
    checks++;
    if (end_oe !== 4'h0) begin errors++; $display("FAIL read_end_oe: got %h want 0", end_oe); end
  endtask

  task automatic test_wrap;
    logic [3:0] want[4] = '{4'h1, 4'h1, 4'h2, 4'h2};
    frm.delete();
    push_byte(8'h02); push_byte(8'h07); push_byte(8'h11); push_byte(8'h22);
    model_frame(0);
    drive_frame(0);
    checks++;
    if (obs_dbg[7] !== 8'h22) begin errors++; $display("FAIL wrap_reg0: got %h want 22", obs_dbg[7]); end
    frm.delete();
    push_byte(8'h0B); push_byte(8'h07);
    repeat (5) frm.push_back(4'($urandom));
    model_frame(7);
    drive_frame(7);
    for (int k = 0; k < exp_oe.size(); k++) begin
      checks++;
      if (obs_oe[k] !== exp_oe[k] || obs_dbg[k] !== exp_dbg[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
        errors++;
        $display("FAIL wrap edge %0d: got oe=%h dout=%h dbg=%h, want oe=%h dout=%h dbg=%h",
                 k, obs_oe[k], obs_do[k], obs_dbg[k], exp_oe[k], exp_do[k], exp_dbg[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_do[5+i] !== want[i]) begin
        errors++;
        $display("FAIL wrap_nibble%0d: got %h want %h", i, obs_do[5+i], want[i]);
      end
    end
  endtask

  task automatic test_abort;
    frm.delete();
    push_byte(8'h02); push_byte(8'h01); frm.push_back(4'hC);
    model_frame(1);
    drive_frame(1);
    #1;
    checks++;
    if (dbg_byte !== 8'h00) begin errors++; $display("FAIL abort_reg1: got %h want 00", dbg_byte); end
    frm.delete();
    push_byte(8'h7E); push_byte(8'h03); push_byte(8'hFF); push_byte(8'hEE);
    model_frame(3);
    drive_frame(3);
    for (int k = 0; k < exp_oe.size(); k++) begin
      checks++;
      if (obs_oe[k] !== exp_oe[k] || obs_dbg[k] !== exp_dbg[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
        errors++;
        $display("FAIL unknown_cmd edge %0d: got oe=%h dbg=%h, want oe=%h dbg=%h",
                 k, obs_oe[k], obs_dbg[k], exp_oe[k], exp_dbg[k]);
      end
    end
    checks++;
    if (obs_dbg[7] !== 8'hA5) begin errors++; $display("FAIL unknown_reg3: got %h want A5", obs_dbg[7]); end
  endtask

  task automatic test_reset_mid_read;
    logic [3:0] wr_nibs[6] = '{4'h0, 4'h2, 4'h0, 4'h1, 4'hF, 4'hF};
    frm.delete();
    push_byte(8'h0B); push_byte(8'h03);
    frm.push_back(4'h0); frm.push_back(4'h0);
    foreach (frm[i]) begin
      @(negedge clk); spi_cs = 1'b1; spi_d_in = frm[i];
      @(posedge clk);
    end
    #1;
    checks++;
    if (spi_d_oe !== 4'hF) begin errors++; $display("FAIL midrst_pre_oe: got %h want F", spi_d_oe); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (spi_d_oe !== 4'h0) begin errors++; $display("FAIL midrst_oe: got %h want 0", spi_d_oe); end
    @(negedge clk); rst = 1'b0;
    // spi_cs never dropped, so this write must be ignored
    for (int i = 0; i < 6; i++) begin
      spi_d_in = wr_nibs[i];
      @(posedge clk); #1;
      checks++;
      if (spi_d_oe !== 4'h0) begin errors++; $display("FAIL midrst_ignore_oe%0d: got %h want 0", i, spi_d_oe); end
      @(negedge clk);
    end
    spi_cs = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i); #1;
      checks++;
      if (dbg_byte !== 8'h00) begin errors++; $display("FAIL midrst_reg%0d: got %h want 00", i, dbg_byte); end
    end
    foreach (mregs[i]) mregs[i] = 8'h00;
    merr = 0;
  endtask

  task automatic test_status;
`ifdef SPI_STATUS_CMD_EN
    logic [3:0] w3[4] = '{4'h0, 4'h3, 4'h0, 4'h3};
`endif
    frm.delete(); push_byte(8'h06);
    model_frame(0); drive_frame(0);
    repeat (3) begin
      frm.delete(); push_byte(8'h7E); frm.push_back(4'h1);
      model_frame(0); drive_frame(0);
    end
    frm.delete(); push_byte(8'h05); repeat (6) frm.push_back(4'($urandom));
    model_frame(0); drive_frame(0);
    for (int k = 0; k < exp_oe.size(); k++) begin
      checks++;
      if (obs_oe[k] !== exp_oe[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
        errors++;
        $display("FAIL status edge %0d: got oe=%h dout=%h, want oe=%h dout=%h",
                 k, obs_oe[k], obs_do[k], exp_oe[k], exp_do[k]);
      end
    end
`ifdef SPI_STATUS_CMD_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_do[3+i] !== w3[i]) begin errors++; $display("FAIL status_cnt%0d: got %h want %h", i, obs_do[3+i], w3[i]); end
    end
    frm.delete(); push_byte(8'h06);
    model_frame(0); drive_frame(0);
    frm.delete(); push_byte(8'h05); repeat (2) frm.push_back(4'($urandom));
    model_frame(0); drive_frame(0);
    checks++;
    if (obs_oe[3] !== 4'hF || obs_do[3] !== 4'h0) begin
      errors++;
      $display("FAIL status_cleared: got oe=%h dout=%h, want F/0", obs_oe[3], obs_do[3]);
    end
`else
    checks++;
    if (obs_oe[6] !== 4'h0) begin errors++; $display("FAIL status_disabled_oe: got %h want 0", obs_oe[6]); end
`endif
  endtask

  task automatic test_back_to_back;
    frm.delete();
    push_byte(8'h02); push_byte(8'h06);
    repeat (4) push_byte(8'($urandom));
    model_frame(6); drive_frame(6);
    frm.delete();
    push_byte(8'h0B); push_byte(8'h06);
    repeat (DUMMY + 16) frm.push_back(4'($urandom));
    model_frame(1); drive_frame(1);
    for (int k = 0; k < exp_oe.size(); k++) begin
      checks++;
      if (obs_oe[k] !== exp_oe[k] || obs_dbg[k] !== exp_dbg[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
        errors++;
        $display("FAIL b2b edge %0d: got oe=%h dout=%h dbg=%h, want oe=%h dout=%h dbg=%h",
                 k, obs_oe[k], obs_do[k], obs_dbg[k], exp_oe[k], exp_do[k], exp_dbg[k]);
      end
    end
  endtask

  task automatic test_random;
    int kind, len;
    logic [7:0] c;
    logic [AW-1:0] dsel;
    for (int f = 0; f < 40; f++) begin
      frm.delete();
      kind = int'($urandom_range(0, 3));
      dsel = AW'($urandom);
      case (kind)
        0: begin
          push_byte(8'h02); push_byte(8'($urandom));
          repeat ($urandom_range(0, 5)) push_byte(8'($urandom));
          if ($urandom_range(0, 1) == 1) frm.push_back(4'($urandom));
        end
        1: begin
          push_byte(8'h0B); push_byte(8'($urandom));
          repeat ($urandom_range(0, DUMMY + 12)) frm.push_back(4'($urandom));
        end
        2: begin
          c = 8'($urandom);
          if (c == 8'h02 || c == 8'h0B) c = 8'h7E;
          push_byte(c);
          repeat ($urandom_range(0, 8)) frm.push_back(4'($urandom));
        end
        default: begin
          len = int'($urandom_range(0, 3));
          repeat (len) frm.push_back(4'($urandom));
        end
      endcase
      model_frame(dsel);
      drive_frame(dsel);
      for (int k = 0; k < exp_oe.size(); k++) begin
        checks++;
        if (obs_oe[k] !== exp_oe[k] || obs_dbg[k] !== exp_dbg[k] || (exp_oe[k] == 4'hF && obs_do[k] !== exp_do[k])) begin
          errors++;
          $display("FAIL random frame %0d edge %0d: got oe=%h dout=%h dbg=%h, want oe=%h dout=%h dbg=%h",
                   f, k, obs_oe[k], obs_do[k], obs_dbg[k], exp_oe[k], exp_do[k], exp_dbg[k]);
        end
      end
      checks++;
      if (end_oe !== 4'h0) begin errors++; $display("FAIL random frame %0d end_oe: got %h want 0", f, end_oe); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i); #1;
      checks++;
      if (dbg_byte !== mregs[i]) begin errors++; $display("FAIL random_final_reg%0d: got %h want %h", i, dbg_byte, mregs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    test_status();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
